// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Line-refill engine between the data cache and a word-wide synchronous RAM.
//   On a miss it writes back the evicted dirty line (one word per cycle), then
//   reads the missing line (one word per cycle, 1-cycle read latency), builds a
//   128-bit line and hands it to the cache with a one-cycle fetch_enable pulse.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   miss_req      : miss request, only looked at in IDLE
//   miss_addr     : byte address of the missing access (line = [31:4])
//   wb_valid      : evicted line is dirty, sampled together with miss_req
//   wb_addr       : evicted line address ([3:0] ignored)
//   wb_data       : evicted line, word k at [32k +: 32]
//   fetch_data    : refilled line (registered, held until the next refill)
//   fetch_enable  : fetch_data valid this cycle
//   busy          : pipeline stall
//   mem_addr      : word-aligned memory address
//   mem_wr_en     : memory write strobe
//   mem_wdata     : memory write data
//   mem_rdata     : memory read data, valid one cycle after mem_addr
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_req,
  input  logic [ADDR_WIDTH-1:0]            miss_addr,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] wb_data,
  output logic [DATA_WIDTH*BLOCK_SIZE-1:0] fetch_data,
  output logic                             fetch_enable,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_wr_en,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int LINE_W = DATA_WIDTH * BLOCK_SIZE;
  localparam int TAG_W  = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          cnt;
  logic [TAG_W-1:0]    miss_line;
  logic [TAG_W-1:0]    wb_line;
  logic [LINE_W-1:0]   wb_buf;
  logic [1:0]          rd_word;

  // Line offsets are not needed; both addresses are used line-aligned.
  logic unused_offsets;
  assign unused_offsets = ^{miss_addr[3:0], wb_addr[3:0]};

  // Read data arriving at cnt=c belongs to the address issued at cnt=c-1;
  // for cnt=4 the 2-bit wrap gives word 3.
  assign rd_word = cnt[1:0] - 2'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (miss_req) state_nxt = wb_valid ? WB : RD;
      WB:   if (cnt == 3'd3) state_nxt = RD;
      RD:   if (cnt == 3'd4) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word counter, request latches and line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      fetch_data <= '0;
      miss_line  <= '0;
      wb_line    <= '0;
      wb_buf     <= '0;
    end else begin
      case (state)
        IDLE: if (miss_req) begin
          miss_line <= miss_addr[ADDR_WIDTH-1:4];
          wb_line   <= wb_addr[ADDR_WIDTH-1:4];
          wb_buf    <= wb_data;
          cnt       <= '0;
        end
        WB:   cnt <= (cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
        RD: begin
          if (cnt != 3'd0) fetch_data[rd_word*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
          cnt <= cnt + 3'd1;
        end
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs. Everything is forced low while rst is high so that an abort
  // issues no further write on the reset edge and never raises fetch_enable.
  always_comb begin
    mem_addr     = '0;
    mem_wr_en    = 1'b0;
    mem_wdata    = '0;
    fetch_enable = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: busy = miss_req;
        WB: begin
          busy      = 1'b1;
          mem_wr_en = 1'b1;
          mem_addr  = {wb_line, cnt[1:0], 2'b00};
          mem_wdata = wb_buf[cnt[1:0]*DATA_WIDTH +: DATA_WIDTH];
        end
        RD: begin
          busy = 1'b1;
          if (cnt <= 3'd3) mem_addr = {miss_line, cnt[1:0], 2'b00};
        end
        DONE: fetch_enable = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         wb_valid;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic [127:0] fetch_data;
  logic         fetch_enable;
  logic         busy;
  logic [31:0]  mem_addr;
  logic         mem_wr_en;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.DATA_WIDTH(32), .BLOCK_SIZE(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .fetch_data(fetch_data), .fetch_enable(fetch_enable), .busy(busy),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: 256-word synchronous RAM with a backdoor load port.
  logic [31:0] mem [0:255];
  logic        bd_en;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wdata;
    if (bd_en)     mem[bd_idx] <= bd_data;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  // Reference model state and scoreboard queues
  logic [31:0] ref_mem [0:255];
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [127:0] line; int unsigned cyc; } fe_t;
  wr_t         wr_q [$];
  logic [31:0] rd_q [$];
  fe_t         fe_q [$];

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input logic [127:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %h, nothing expected", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ma, input logic wv, input logic [31:0] wa,
                       input logic [127:0] wd);
    miss_addr = ma;
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
  endtask

  // Model: a dirty line is written to memory in word order, then the miss line
  // is read back word by word; data shows up 6 (clean) or 10 (dirty) cycles
  // after the accepting cycle.
  task automatic expect_txn(input logic [31:0] ma, input logic wv, input logic [31:0] wa,
                            input logic [127:0] wd, input int unsigned acc);
    logic [127:0] line;
    wr_t w;
    fe_t f;
    logic [1:0] kk;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      if (wv) begin
        w.addr = {wa[31:4], kk, 2'b00};
        w.data = wd[32*k +: 32];
        wr_q.push_back(w);
        ref_mem[{wa[9:4], kk}] = w.data;
      end
    end
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      rd_q.push_back({ma[31:4], kk, 2'b00});
      line[32*k +: 32] = ref_mem[{ma[9:4], kk}];
    end
    f.line = line;
    f.cyc  = acc + (wv ? 10 : 6);
    fe_q.push_back(f);
  endtask

  task automatic wait_done();
    int lim = 0;
    while ((fe_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && lim < 40) begin
      tick();
      lim++;
    end
    if (lim >= 40) begin
      fail_msg("timeout waiting for refill", 128'(fe_q.size()));
      wr_q.delete(); rd_q.delete(); fe_q.delete();
    end
  endtask

  // One refill; with junk set, miss_req and request inputs toggle randomly
  // while the engine is in WB/RD (it must ignore them), dropped before DONE.
  task automatic run_txn(input logic [31:0] ma, input logic wv, input logic [31:0] wa,
                         input logic [127:0] wd, input bit junk);
    int unsigned acc, done_c;
    int lim;
    acc    = cyc;
    done_c = acc + (wv ? 10 : 6);
    drive(ma, wv, wa, wd);
    miss_req = 1'b1;
    expect_txn(ma, wv, wa, wd, acc);
    #1 check("busy on request", 128'(busy), 128'(1));
    tick();
    lim = 0;
    while ((fe_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && lim < 40) begin
      if (junk && cyc < done_c) begin
        miss_req = 1'($urandom);
        drive({22'b0, 6'($urandom), 4'h0}, 1'($urandom), {22'b0, 6'($urandom), 4'h0},
              {$urandom, $urandom, $urandom, $urandom});
      end else begin
        miss_req = 1'b0;
      end
      tick();
      lim++;
    end
    miss_req = 1'b0;
    if (lim >= 40) begin
      fail_msg("timeout waiting for refill", 128'(fe_q.size()));
      wr_q.delete(); rd_q.delete(); fe_q.delete();
    end
  endtask

  // Monitor: compares every memory access and every fetch_enable against the queues.
  wr_t         m_wr;
  logic [31:0] m_rd;
  fe_t         m_fe;
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (mem_wr_en) begin
        if (wr_q.size() == 0) fail_msg("unexpected write", {64'b0, mem_addr, mem_wdata});
        else begin
          m_wr = wr_q.pop_front();
          check("write addr", 128'(mem_addr), 128'(m_wr.addr));
          check("write data", 128'(mem_wdata), 128'(m_wr.data));
        end
      end else begin
        check("wdata idle", 128'(mem_wdata), 128'(0));
        if (busy && mem_addr != 32'd0) begin
          if (rd_q.size() == 0) fail_msg("unexpected read", 128'(mem_addr));
          else begin
            m_rd = rd_q.pop_front();
            check("read addr", 128'(mem_addr), 128'(m_rd));
          end
        end
      end
      if (fetch_enable) begin
        if (fe_q.size() == 0) fail_msg("unexpected fetch_enable", fetch_data);
        else begin
          m_fe = fe_q.pop_front();
          check("fetch cycle", 128'(cyc), 128'(m_fe.cyc));
          check("fetch data", fetch_data, m_fe.line);
          check("busy in DONE", 128'(busy), 128'(0));
        end
      end
    end
  end

  initial begin
    int unsigned acc;
    logic [5:0]  ml, wl;
    rst = 1'b1;
    miss_req = 1'b0;
    bd_en = 1'b0; bd_idx = '0; bd_data = '0;
    drive('0, 1'b0, '0, '0);
    tick(); tick();

    // Backdoor preload; words 0x40..0x43 (addr 0x100..0x10C) = A0..A3
    for (int i = 0; i < 256; i++) begin
      bd_en   = 1'b1;
      bd_idx  = 8'(i);
      bd_data = (i >= 64 && i < 68) ? 32'(160 + i - 64) : $urandom;
      ref_mem[i] = bd_data;
      tick();
    end
    bd_en = 1'b0;

    // Reset state, including busy held low with miss_req high
    miss_req = 1'b1;
    #1;
    check("reset busy",         128'(busy),         128'(0));
    check("reset fetch_enable", 128'(fetch_enable), 128'(0));
    check("reset mem_wr_en",    128'(mem_wr_en),    128'(0));
    check("reset mem_addr",     128'(mem_addr),     128'(0));
    check("reset fetch_data",   fetch_data,         128'(0));
    miss_req = 1'b0;
    tick();
    rst = 1'b0;
    mon_on = 1'b1;
    tick();

    // Clean miss
    run_txn(32'h108, 1'b0, 32'h0, 128'h0, 1'b0);
    check("clean line", fetch_data, 128'h000000A3_000000A2_000000A1_000000A0);

    // Dirty miss
    run_txn(32'h300, 1'b1, 32'h20, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);

    // Same-line write-back then read
    run_txn(32'h40, 1'b1, 32'h40, {32'h11, 32'hDEAD, 32'h22, 32'h33}, 1'b0);
    check("same-line word2", 128'(fetch_data[95:64]), 128'(32'hDEAD));

    // Reset after two write-back words
    acc = cyc;
    drive(32'h300, 1'b1, 32'h20, {32'h14, 32'h13, 32'h12, 32'h11});
    miss_req = 1'b1;
    m_wr.addr = 32'h20; m_wr.data = 32'h11; wr_q.push_back(m_wr);
    m_wr.addr = 32'h24; m_wr.data = 32'h12; wr_q.push_back(m_wr);
    ref_mem[8] = 32'h11;
    ref_mem[9] = 32'h12;
    tick();
    miss_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort accepted at cycle", 128'(cyc - acc), 128'(4));
    check("abort busy",       128'(busy),      128'(0));
    check("abort mem_wr_en",  128'(mem_wr_en), 128'(0));
    check("abort mem_addr",   128'(mem_addr),  128'(0));
    check("abort fetch_data", fetch_data,      128'(0));
    check("abort writes left", 128'(wr_q.size()), 128'(0));
    check("abort mem 0x20", 128'(mem[8]),  128'(ref_mem[8]));
    check("abort mem 0x24", 128'(mem[9]),  128'(ref_mem[9]));
    check("abort mem 0x28", 128'(mem[10]), 128'(ref_mem[10]));
    check("abort mem 0x2C", 128'(mem[11]), 128'(ref_mem[11]));
    repeat (12) tick();
    run_txn(32'h10C, 1'b0, 32'h0, 128'h0, 1'b0);

    // Requests toggled during the transfer must be ignored
    run_txn(32'h200, 1'b1, 32'h380, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

    // miss_req held through DONE: second refill starts right after, pulses 7 apart
    acc = cyc;
    drive(32'h100, 1'b0, 32'h0, 128'h0);
    miss_req = 1'b1;
    expect_txn(32'h100, 1'b0, 32'h0, 128'h0, acc);
    tick();
    drive(32'h2C4, 1'b0, 32'h0, 128'h0);
    expect_txn(32'h2C4, 1'b0, 32'h0, 128'h0, acc + 7);
    while (cyc < acc + 7) tick();
    tick();
    miss_req = 1'b0;
    wait_done();

    // Randomized refills
    for (int n = 0; n < 30; n++) begin
      ml = 6'($urandom_range(1, 63));
      wl = ($urandom_range(0, 3) == 0) ? ml : 6'($urandom);
      run_txn({22'b0, ml, 4'($urandom)}, 1'($urandom), {22'b0, wl, 4'($urandom)},
              {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
